alu_rr_scheduler: RTL and testbench
===================================

// Module: alu_rr_scheduler
// PURPOSE
//  Shares one combinational 4-op ALU among NUM_REQ requesters. Round-robin
//  arbitration; each granted op is captured, executed and returned on one
//  response channel tagged with the requester id. Sits between the issuing
//  units and the shared ALU datapath; it is the only driver of the ALU inputs.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  WIDTH    4  operand/result width
//  OP_W     2  opcode width; 0=ADD 1=SUB 2=AND 3=OR
//  CNT_W    8  width of completed-op counter
// PORTS
//  clk         in   1               clock, rising edge
//  rst_n       in   1               async active-low reset
//  req_valid   in   NUM_REQ         per-requester request valid
//  req_ready   out  NUM_REQ         per-requester accept (one-hot or zero)
//  req_a       in   NUM_REQ*WIDTH   operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b       in   NUM_REQ*WIDTH   operand B, same packing
//  req_op      in   NUM_REQ*OP_W    opcode, same packing
//  rsp_valid   out  1               response valid
//  rsp_ready   in   1               response consumer ready
//  rsp_id      out  $clog2(NUM_REQ) requester index of the response
//  rsp_result  out  WIDTH           ALU result
//  busy        out  1               high when state != IDLE
//  ops_done    out  CNT_W           completed responses, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0,
//   rsp_result=0, busy=0, ops_done=0, rr_ptr=NUM_REQ-1 (req 0 wins first).
//  Reset mid-operation discards captured op and any pending response.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: grant = first i with req_valid[i], scanning rr_ptr+1, rr_ptr+2, ...
//    modulo NUM_REQ. req_ready[grant]=1 combinationally, same cycle; no
//    valid -> all ready 0, stay IDLE. On the handshake, register a,b,op,id -> EXEC.
//   EXEC: drive captured a,b,op to ALU; register result in rsp_result,
//    rsp_id=captured id -> RESP.
//   RESP: rsp_valid=1; rsp_id/rsp_result stable until rsp_ready=1. On
//    rsp_valid&&rsp_ready: rr_ptr=rsp_id, ops_done+=1, -> IDLE.
//  req_ready is 0 in EXEC and RESP. A requester may drop or change req_valid
//   freely; only the handshake cycle counts.
//  Latency: accept in cycle N -> rsp_valid in cycle N+2. Max rate: 1 op per
//   3 cycles with rsp_ready tied high.
//  Arithmetic: ADD/SUB modulo 2^WIDTH, no carry/borrow out; AND/OR bitwise.
//  Simultaneous requests: exactly one grant per IDLE cycle; the granted id
//   becomes lowest priority for the next arbitration.
//  rsp_ready held low: stay in RESP indefinitely, no new grants.
// STRUCTURE
//  Package alu_pkg: opcode localparams OP_ADD/OP_SUB/OP_AND/OP_OR, OP_W,
//   state enum {IDLE, EXEC, RESP}.
//  Sub-module rr_arbiter #(NUM_REQ): inputs req vector, ptr; output
//   one-hot grant and grant index. The ALU is the team's existing
//   combinational ALU, instantiated once, fed only from capture registers.
// TESTING
//  1 single op: req0 a=3 b=2 op=ADD -> ready0 same cycle; 2 cycles later
//    rsp_valid, id=0, result=5; ops_done=1.
//  2 all ops: a=3 b=2 on req1, op 0..3 -> results 5,1,2,3; a=2 b=3 SUB -> 15.
//  3 fairness: all 4 valid continuously, rsp_ready=1 -> grant order
//    0,1,2,3,0,...; every op returns its own id.
//  4 backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp fields stable,
//    req_ready all 0, busy=1; release -> one transfer, back to IDLE.
//  5 reset in EXEC: rst_n low 1 cycle -> all outputs 0 immediately, no
//    response; next request from req2 only -> granted, id=2.
//  6 counter wrap: CNT_W=2, 5 ops -> ops_done 1,2,3,0,1.

Source files
------------

// File: rtl/alu_rr_scheduler_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcodes and FSM states.
package alu_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W-1:0] OP_AND = 2'd2;
  localparam logic [OP_W-1:0] OP_OR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the issuing units and the ALU scheduler.
interface alu_rr_scheduler_if
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned OP_W_P  = OP_W,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*WIDTH-1:0]  req_a;
  logic [NUM_REQ*WIDTH-1:0]  req_b;
  logic [NUM_REQ*OP_W_P-1:0] req_op;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [WIDTH-1:0]          rsp_result;
  logic                      busy;
  logic [CNT_W-1:0]          ops_done;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, busy, ops_done
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, busy, ops_done
  );

endinterface

// File: rtl/alu_rr_scheduler_alu.sv
// Shared combinational ALU: modular add/sub and bitwise and/or.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_scheduler_arb.sv
// Round-robin arbiter: first requester after ptr (modulo NUM_REQ) wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters;
// one op in flight, result returned tagged with the requester id.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_rr_scheduler_if.slave bus
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    cap_id;
  logic [WIDTH-1:0]   cap_a;
  logic [WIDTH-1:0]   cap_b;
  logic [OP_W-1:0]    cap_op;
  logic [WIDTH-1:0]   alu_y;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               accept_c;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [OP_W-1:0]    sel_op;

  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic               busy_q;
  logic [CNT_W-1:0]   ops_done_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Grant is only offered while idle and out of reset, so ready stays 0 in reset.
  assign accept_c      = (state == IDLE) && rst_n && grant_any;
  assign bus.req_ready = accept_c ? grant : '0;

  assign sel_a  = bus.req_a[grant_idx*WIDTH +: WIDTH];
  assign sel_b  = bus.req_b[grant_idx*WIDTH +: WIDTH];
  assign sel_op = bus.req_op[grant_idx*OP_W +: OP_W];

  alu #(.WIDTH(WIDTH)) u_alu (
    .a  (cap_a),
    .b  (cap_b),
    .op (cap_op),
    .y  (alu_y)
  );

  // Capture -> execute -> respond; rr_ptr advances only on response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= ID_W'(NUM_REQ - 1);
      cap_id       <= '0;
      cap_a        <= '0;
      cap_b        <= '0;
      cap_op       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      busy_q       <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            cap_a  <= sel_a;
            cap_b  <= sel_b;
            cap_op <= sel_op;
            cap_id <= grant_idx;
            busy_q <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_y;
          rsp_id_q     <= cap_id;
          rsp_valid_q  <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr      <= rsp_id_q;
            ops_done_q  <= ops_done_q + CNT_W'(1);
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.busy       = busy_q;
  assign bus.ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler against a transaction-level model.
module tb_alu_rr_scheduler;

  logic clk;
  logic rst_n;

  alu_rr_scheduler_if #(.NUM_REQ(4), .WIDTH(4), .CNT_W(8)) bus ();
  alu_rr_scheduler_if #(.NUM_REQ(4), .WIDTH(4), .CNT_W(2)) bus2 ();

  alu_rr_scheduler #(.NUM_REQ(4), .WIDTH(4), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  alu_rr_scheduler #(.NUM_REQ(4), .WIDTH(4), .CNT_W(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  int m_ptr  = 3;
  int m_ops  = 0;
  int m_age  = 0;
  bit m_busy = 1'b0;
  int q_id   = 0;
  int q_res  = 0;
  int grants[$];

  function automatic int alu_ref(input int a, input int b, input int op);
    case (op)
      0:       return (a + b) % 16;
      1:       return (a - b + 16) % 16;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic int model_grant(input logic [3:0] vec, input int ptr);
    for (int k = 1; k <= 4; k++) begin
      if (vec[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] op, input logic rr);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.rsp_ready = rr;
  endtask

  // One clock of random operands, checked against the model and then advancing it.
  task automatic sb_cycle(input logic [3:0] vec, input logic rr);
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  op;
    logic [3:0]  exp_ready;
    bit          exp_rv;
    int          g;
    a  = 16'($urandom);
    b  = 16'($urandom);
    op = 8'($urandom);
    step();
    if (m_busy) m_age++;
    drive(vec, a, b, op, rr);
    #1;
    g         = m_busy ? -1 : model_grant(vec, m_ptr);
    exp_ready = (g < 0) ? 4'b0 : 4'(1 << g);
    exp_rv    = m_busy && (m_age >= 2);
    checks++;
    if (bus.busy !== m_busy) begin
      errors++; $display("FAIL sb_busy: got %0b expected %0b", bus.busy, m_busy);
    end
    checks++;
    if (bus.ops_done !== 8'(m_ops)) begin
      errors++; $display("FAIL sb_ops_done: got %0d expected %0d", bus.ops_done, m_ops);
    end
    checks++;
    if (bus.req_ready !== exp_ready) begin
      errors++; $display("FAIL sb_req_ready: got %b expected %b", bus.req_ready, exp_ready);
    end
    checks++;
    if (bus.rsp_valid !== exp_rv) begin
      errors++; $display("FAIL sb_rsp_valid: got %0b expected %0b", bus.rsp_valid, exp_rv);
    end
    if (exp_rv) begin
      checks++;
      if (bus.rsp_id !== 2'(q_id) || bus.rsp_result !== 4'(q_res)) begin
        errors++;
        $display("FAIL sb_rsp: got id=%0d res=%0d expected id=%0d res=%0d",
                 bus.rsp_id, bus.rsp_result, q_id, q_res);
      end
    end
    if (g >= 0) begin
      m_busy = 1'b1;
      m_age  = 0;
      q_id   = g;
      q_res  = alu_ref(int'(a[g*4 +: 4]), int'(b[g*4 +: 4]), int'(op[g*2 +: 2]));
      grants.push_back(g);
    end else if (exp_rv && rr) begin
      m_busy = 1'b0;
      m_ptr  = q_id;
      m_ops++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'b0, 16'h0, 16'h0, 8'h0, 1'b0);
    bus2.req_valid = '0; bus2.req_a = '0; bus2.req_b = '0; bus2.req_op = '0; bus2.rsp_ready = 1'b0;
    step();
    step();
    checks++;
    if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got ready=%b rv=%0b busy=%0b expected 0", bus.req_ready, bus.rsp_valid, bus.busy);
    end
    checks++;
    if (bus.rsp_id !== 2'd0 || bus.rsp_result !== 4'd0 || bus.ops_done !== 8'd0) begin
      errors++; $display("FAIL reset_data: got id=%0d res=%0d ops=%0d expected 0", bus.rsp_id, bus.rsp_result, bus.ops_done);
    end
    rst_n = 1'b1;
    m_ptr = 3; m_ops = 0; m_busy = 1'b0;
  endtask

  task automatic test_fairness();
    grants.delete();
    for (int c = 0; c < 60 && grants.size() < 8; c++) sb_cycle(4'hF, 1'b1);
    for (int c = 0; c < 10 && m_busy; c++) sb_cycle(4'h0, 1'b1);
    checks++;
    if (grants.size() != 8 || m_busy) begin
      errors++; $display("FAIL fair_count: got %0d grants expected 8", grants.size());
    end
    for (int i = 0; i < grants.size(); i++) begin
      checks++;
      if (grants[i] != i % 4) begin
        errors++; $display("FAIL fair_order[%0d]: got %0d expected %0d", i, grants[i], i % 4);
      end
    end
  endtask

  task automatic test_single();
    step();
    drive(4'b0001, 16'h0003, 16'h0002, 8'h00, 1'b1);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0) begin
      errors++; $display("FAIL single_exec: got rv=%0b busy=%0b ready=%b expected 0,1,0000", bus.rsp_valid, bus.busy, bus.req_ready);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_result !== 4'd5) begin
      errors++; $display("FAIL single_rsp: got rv=%0b id=%0d res=%0d expected 1,0,5", bus.rsp_valid, bus.rsp_id, bus.rsp_result);
    end
    step();
    m_ops++; m_ptr = 0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ops_done !== 8'(m_ops)) begin
      errors++; $display("FAIL single_done: got rv=%0b busy=%0b ops=%0d expected 0,0,%0d", bus.rsp_valid, bus.busy, bus.ops_done, m_ops);
    end
  endtask

  task automatic test_all_ops();
    int exp_res[5] = '{5, 1, 2, 3, 15};
    int a, b, op;
    for (int k = 0; k < 5; k++) begin
      a  = (k < 4) ? 3 : 2;
      b  = (k < 4) ? 2 : 3;
      op = (k < 4) ? k : 1;
      step();
      drive(4'b0010, 16'(a << 4), 16'(b << 4), 8'(op << 2), 1'b1);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010) begin
        errors++; $display("FAIL ops_ready[%0d]: got %b expected 0010", k, bus.req_ready);
      end
      step();
      bus.req_valid = 4'b0;
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_result !== 4'(exp_res[k])) begin
        errors++; $display("FAIL ops_rsp[%0d]: got rv=%0b id=%0d res=%0d expected 1,1,%0d", k, bus.rsp_valid, bus.rsp_id, bus.rsp_result, exp_res[k]);
      end
      step();
      m_ops++; m_ptr = 1;
      checks++;
      if (bus.ops_done !== 8'(m_ops)) begin
        errors++; $display("FAIL ops_count[%0d]: got %0d expected %0d", k, bus.ops_done, m_ops);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a  = 16'h7531;
    logic [15:0] b  = 16'h2468;
    logic [7:0]  op = 8'b11_10_01_00;
    int g, res;
    g   = model_grant(4'hF, m_ptr);
    res = alu_ref(int'(a[g*4 +: 4]), int'(b[g*4 +: 4]), int'(op[g*2 +: 2]));
    step();
    drive(4'hF, a, b, op, 1'b0);
    #1;
    checks++;
    if (bus.req_ready !== 4'(1 << g)) begin
      errors++; $display("FAIL bp_grant: got %b expected %b", bus.req_ready, 4'(1 << g));
    end
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(g) || bus.rsp_result !== 4'(res) ||
          bus.req_ready !== 4'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rv=%0b id=%0d res=%0d ready=%b busy=%0b expected 1,%0d,%0d,0000,1",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req_ready, bus.busy, g, res);
      end
    end
    drive(4'h0, a, b, op, 1'b1);
    step();
    m_ops++; m_ptr = g;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ops_done !== 8'(m_ops)) begin
      errors++; $display("FAIL bp_release: got rv=%0b busy=%0b ops=%0d expected 0,0,%0d", bus.rsp_valid, bus.busy, bus.ops_done, m_ops);
    end
  endtask

  task automatic test_reset_exec();
    step();
    drive(4'b0010, 16'h0050, 16'h0040, 8'h00, 1'b1);
    step();
    bus.req_valid = 4'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.rsp_id !== 2'd0 || bus.rsp_result !== 4'd0 || bus.ops_done !== 8'd0) begin
      errors++;
      $display("FAIL rexec_outputs: got ready=%b rv=%0b busy=%0b id=%0d res=%0d ops=%0d expected all 0",
               bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_result, bus.ops_done);
    end
    step();
    rst_n = 1'b1;
    m_ptr = 3; m_ops = 0; m_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL rexec_norsp[%0d]: got rv=%0b busy=%0b expected 0,0", c, bus.rsp_valid, bus.busy);
      end
    end
    drive(4'b0100, 16'h0900, 16'h0800, 8'h00, 1'b1);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL rexec_grant: got %b expected 0100", bus.req_ready);
    end
    step();
    bus.req_valid = 4'b0;
    step();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_result !== 4'(alu_ref(9, 8, 0))) begin
      errors++; $display("FAIL rexec_rsp: got rv=%0b id=%0d res=%0d expected 1,2,%0d", bus.rsp_valid, bus.rsp_id, bus.rsp_result, alu_ref(9, 8, 0));
    end
    step();
    m_ops++; m_ptr = 2;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) sb_cycle(4'($urandom), ($urandom_range(0, 3) != 0));
    for (int c = 0; c < 10 && m_busy; c++) sb_cycle(4'h0, 1'b1);
    checks++;
    if (m_busy) begin
      errors++; $display("FAIL random_drain: got busy model=1 expected 0");
    end
  endtask

  task automatic test_wrap();
    int exp_cnt[5] = '{1, 2, 3, 0, 1};
    for (int k = 0; k < 5; k++) begin
      step();
      bus2.req_valid = 4'b0001; bus2.req_a = 16'h0001; bus2.req_b = 16'h0001; bus2.rsp_ready = 1'b1;
      step();
      bus2.req_valid = 4'b0;
      step();
      step();
      checks++;
      if (bus2.ops_done !== 2'(exp_cnt[k])) begin
        errors++; $display("FAIL wrap[%0d]: got %0d expected %0d", k, bus2.ops_done, exp_cnt[k]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_all_ops();
    test_backpressure();
    test_reset_exec();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
